// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    // Level of an idle (marking) serial line; also the synchroniser reset value.
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin.
// Resets to the idle line level so a reset never looks like a start edge.
module uart_rx_sync
    import uart_pkg::*;
(
    input  logic clock_i,
    input  logic reset_i,
    input  logic rx_i,
    output logic rx_s_o
);

    logic [1:0] sync_q;

    // Shift the raw pin through two flops before anything else looks at it.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            sync_q <= {2{UART_IDLE_LEVEL}};
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rx_s_o = sync_q[1];

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage driven by a SAMPLE_RATE-per-bit oversampling tick.
// Hunts for a start bit, samples each bit at mid-bit, assembles an LSB-first
// word and presents it on a valid/ready handshake with per-frame error flags.
// Optional parity bit support: define UART_RX_PARITY_EN.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | line idle, waiting for a falling edge (armed by a high level)
//   START  | counting to mid start bit to reject glitches
//   DATA   | sampling DATA_BITS payload bits, one per SAMPLE_RATE ticks
//   PARITY | sampling the parity bit (only with UART_RX_PARITY_EN)
//   STOP   | sampling the stop bit; frame completes here at mid-stop
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int SAMPLE_RATE = 16,
    parameter int PARITY_ODD  = 0
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 tick_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 framing_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int TW = $clog2(SAMPLE_RATE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] TICK_MID = TW'(SAMPLE_RATE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(SAMPLE_RATE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    if ((DATA_BITS < 5) || (DATA_BITS > 9) || (SAMPLE_RATE < 4) ||
        ((SAMPLE_RATE % 2) != 0) || (PARITY_ODD < 0) || (PARITY_ODD > 1)) begin : g_bad_params
        $error("uart_receiver: unsupported parameter combination");
    end

    logic                 rx_s;
    rx_state_t            state_q;
    logic [TW-1:0]        tick_cnt_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic                 armed_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 framing_err_q;
    logic                 overrun_q;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = (PARITY_ODD != 0);
    logic                 parity_pend_q;
    logic                 parity_err_q;
`endif

    uart_rx_sync u_sync (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .rx_i    (rx_i),
        .rx_s_o  (rx_s)
    );

    // Line order is LSB first, so each new bit enters at the top and moves down.
    assign shift_d = {rx_s, shift_q[DATA_BITS-1:1]};

    // Receive FSM, bit timing counters, shift register and output handshake.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            armed_q       <= 1'b1;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_pend_q <= 1'b0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            overrun_q <= 1'b0;
            if (rx_valid_q && rx_ready_i) begin
                rx_valid_q <= 1'b0;
            end
            // A low line only counts as a start edge once it has been seen high,
            // so a held break does not retrigger frames.
            if (rx_s) begin
                armed_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (!rx_s && armed_q) begin
                        state_q    <= START;
                        tick_cnt_q <= '0;
                    end
                end

                START: begin
                    if (tick_i) begin
                        if (tick_cnt_q == TICK_MID) begin
                            tick_cnt_q <= '0;
                            if (!rx_s) begin
                                state_q   <= DATA;
                                bit_cnt_q <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (tick_i) begin
                        if (tick_cnt_q == TICK_END) begin
                            tick_cnt_q <= '0;
                            shift_q    <= shift_d;
                            bit_cnt_q  <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state_q <= PARITY;
`else
                                state_q <= STOP;
`endif
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (tick_i) begin
                        if (tick_cnt_q == TICK_END) begin
                            tick_cnt_q    <= '0;
                            parity_pend_q <= rx_s ^ (^shift_q) ^ PAR_ODD;
                            state_q       <= STOP;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end
`endif

                STOP: begin
                    if (tick_i) begin
                        if (tick_cnt_q == TICK_END) begin
                            // Leave at mid-stop so the next start edge is caught at once.
                            tick_cnt_q <= '0;
                            state_q    <= IDLE;
                            armed_q    <= rx_s;
                            if (!rx_valid_q || rx_ready_i) begin
                                rx_data_q     <= shift_q;
                                rx_valid_q    <= 1'b1;
                                framing_err_q <= !rx_s;
`ifdef UART_RX_PARITY_EN
                                parity_err_q  <= parity_pend_q;
`endif
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_q    <= IDLE;
                    tick_cnt_q <= '0;
                end
            endcase
        end
    end

    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign framing_err_o = framing_err_q;
    assign overrun_o     = overrun_q;
    assign busy_o        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_err_o  = parity_err_q;
`else
    assign parity_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: directed frames plus random frames, checked by a
// queue-based scoreboard popped whenever the DUT hands over a word.
module tb_uart_receiver;

    localparam int DB      = 8;
    localparam int SR      = 16;
    localparam int PODD    = 0;
    localparam int BIT_CLK = SR * 4;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          tick  = 1'b0;
    logic          rx    = 1'b1;
    logic          rx_ready = 1'b1;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          framing_err;
    logic          parity_err;
    logic          overrun;
    logic          busy;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          ferr;
        logic          perr;
    } exp_t;

    exp_t expq[$];
    int   total   = 0;
    int   bad     = 0;
    int   ovr_seen = 0;
    int   exp_ovr  = 0;

    uart_receiver #(
        .DATA_BITS   (DB),
        .SAMPLE_RATE (SR),
        .PARITY_ODD  (PODD)
    ) dut (
        .clock_i       (clock),
        .reset_i       (reset),
        .tick_i        (tick),
        .rx_i          (rx),
        .rx_data_o     (rx_data),
        .rx_valid_o    (rx_valid),
        .rx_ready_i    (rx_ready),
        .framing_err_o (framing_err),
        .parity_err_o  (parity_err),
        .overrun_o     (overrun),
        .busy_o        (busy)
    );

    always #5 clock = ~clock;

    // Oversampling strobe: one clock high out of every four.
    initial begin : tick_gen
        int c;
        c = 0;
        forever begin
            @(posedge clock);
            #1;
            tick = (c == 3);
            c = (c + 1) % 4;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every handover and every overrun pulse is accounted against the scoreboard.
    always @(negedge clock) begin : monitor
        exp_t e;
        exp_t a;
        if (!reset) begin
            if (overrun === 1'b1) ovr_seen++;
            if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
                total++;
                a = '{data: rx_data, ferr: framing_err, perr: parity_err};
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_word actual=%0h required=none", a);
                end else begin
                    e = expq.pop_front();
                    if (a !== e) begin
                        bad++;
                        $display("FAIL word actual data=%0h ferr=%0b perr=%0b required data=%0h ferr=%0b perr=%0b",
                                 a.data, a.ferr, a.perr, e.data, e.ferr, e.perr);
                    end
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (BIT_CLK) @(posedge clock);
        #1;
    endtask

    // Drives one frame; corrupt inverts the correct parity bit. If expect_word,
    // the word the line carries is pushed to the scoreboard first.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_b,
                              input logic corrupt, input bit expect_word);
        logic pbit;
        exp_t e;
        pbit = ((($countones(d) + PODD) % 2) != 0) ^ corrupt;
        if (expect_word) begin
            e.data = d;
            e.ferr = (stop_b == 1'b0);
            e.perr = PAR_EN && ((($countones(d) + int'(pbit)) % 2) != PODD);
            expq.push_back(e);
        end
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        if (PAR_EN) send_bit(pbit);
        send_bit(stop_b);
        rx = 1'b1;
    endtask

    initial begin : watchdog
        #(90000 * 10);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int wait_cnt;
        logic [DB-1:0] d;
        logic sb;
        logic cr;

        reset = 1'b1;
        rx = 1'b1;
        rx_ready = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("rst_data", 32'(rx_data), 32'h0);
        check("rst_valid", 32'(rx_valid), 32'h0);
        check("rst_ferr", 32'(framing_err), 32'h0);
        check("rst_perr", 32'(parity_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);

        // Good frame, consumer always ready.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        send_bit(1'b1);
        check("a5_drained", 32'(expq.size()), 32'h0);

        // Short low glitch: rejected at mid start bit.
        rx = 1'b0;
        repeat (12) @(posedge clock);
        #1;
        check("glitch_busy_rise", 32'(busy), 32'h1);
        rx = 1'b1;
        wait_cnt = 0;
        while (busy === 1'b1 && wait_cnt < 40) begin
            @(posedge clock);
            #1;
            wait_cnt++;
        end
        check("glitch_busy_fall", 32'(busy), 32'h0);
        send_bit(1'b1);

        // Stop bit low: word still delivered, with framing error.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        check("3c_drained", 32'(expq.size()), 32'h0);

        // Back-to-back with consumer stalled: second frame is dropped.
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        exp_ovr++;
        send_bit(1'b1);
        check("ovr_valid_held", 32'(rx_valid), 32'h1);
        check("ovr_data_held", 32'(rx_data), 32'h11);
        check("ovr_pulses", 32'(ovr_seen), 32'(exp_ovr));
        rx_ready = 1'b1;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        check("ovr_valid_cleared", 32'(rx_valid), 32'h0);
        check("ovr_drained", 32'(expq.size()), 32'h0);

        // Reset in the middle of a frame of all ones.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        reset = 1'b1;
        rx = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_valid", 32'(rx_valid), 32'h0);
        reset = 1'b0;
        send_bit(1'b1);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
        send_bit(1'b1);
        check("5a_drained", 32'(expq.size()), 32'h0);

        // Parity: correct and inverted parity bit on 0x07.
        if (PAR_EN) begin
            send_frame(8'h07, 1'b1, 1'b0, 1'b1);
            send_bit(1'b1);
            send_frame(8'h07, 1'b1, 1'b1, 1'b1);
            send_bit(1'b1);
        end

        // Random frames with random stop-bit and parity faults and idle gaps.
        for (int n = 0; n < 12; n++) begin
            d  = DB'($urandom_range(0, (1 << DB) - 1));
            sb = ($urandom_range(0, 3) != 0);
            cr = 1'($urandom_range(0, 1));
            send_frame(d, sb, cr, 1'b1);
            if (!sb) send_bit(1'b1);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) send_bit(1'b1);
        end

        wait_cnt = 0;
        while (expq.size() != 0 && wait_cnt < 200) begin
            @(posedge clock);
            #1;
            wait_cnt++;
        end
        check("final_drained", 32'(expq.size()), 32'h0);
        check("final_overruns", 32'(ovr_seen), 32'(exp_ovr));
        check("final_idle", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
